// File: rtl/garduino_adc_pkg.sv
// Shared constants for the garduino ADC capture block: register map,
// STATUS field offsets and the channel ceiling.
package garduino_adc_pkg;

    localparam int MAX_CH  = 8;
    localparam int NEW_LSB = 0;
    localparam int OVR_LSB = 8;

    typedef enum logic [3:0] {
        ADDR_STATUS       = 4'd0,
        ADDR_IRQ_MASK     = 4'd1,
        ADDR_SAMPLE_COUNT = 4'd2,
        ADDR_RESERVED     = 4'd3,
        ADDR_DATA0        = 4'd4
    } reg_addr_e;

    function automatic logic [3:0] popcount(input logic [MAX_CH-1:0] v);
        logic [3:0] n;
        // NOTE: blocking '=' is correct here; this is combinational accumulation, not state.
        n = '0;
        for (int i = 0; i < MAX_CH; i++) n = n + 4'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/garduino_adc_capture_if.sv
// Avalon-MM slave bus of the garduino ADC capture block.
interface garduino_adc_capture_if;

    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);

endinterface

// File: rtl/garduino_adc_chan.sv
// One ADC channel: captured sample plus its NEW / OVR status flags.
module garduino_adc_chan #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_rd_clr,
    input  logic              i_clr_new,
    input  logic              i_clr_ovr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_new,
    output logic              o_ovr
);

    logic              w_ack;
    logic [DATA_W-1:0] r_data;
    logic              r_new;
    logic              r_ovr;

    // The old sample counts as consumed if it is read or its NEW bit is cleared.
    assign w_ack = i_rd_clr | i_clr_new;

    // NOTE: the data register is reset too, because software must read 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_new  <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (i_valid) r_data <= i_data;
            r_new <= i_valid | (r_new & ~w_ack);
            r_ovr <= (i_valid & r_new & ~w_ack) | (r_ovr & ~i_clr_ovr);
        end
    end

    assign o_data = r_data;
    assign o_new  = r_new;
    assign o_ovr  = r_ovr;

endmodule

// File: rtl/garduino_adc_capture.sv
// Multi-channel ADC sample capture with Avalon-MM register access.
// Define GARDUINO_ADC_IRQ_EN to build the IRQ_MASK register and irq output.
module garduino_adc_capture
    import garduino_adc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    garduino_adc_capture_if.slave    bus,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     irq
);

    logic              w_wr_status;
    logic              w_wr_count;
    logic [MAX_CH-1:0] w_valid_ext;
    logic [3:0]        w_pop;
    logic [NUM_CH-1:0] w_new;
    logic [NUM_CH-1:0] w_ovr;
    logic [DATA_W-1:0] w_data [NUM_CH];
    logic [31:0]       w_status;
    logic [31:0]       w_mask_rd;
    logic [31:0]       w_rd_value;
    logic              w_unused_bits;
    logic [31:0]       r_count;
    logic [31:0]       r_readdata;

    assign w_wr_status   = bus.write && (bus.address == ADDR_STATUS);
    assign w_wr_count    = bus.write && (bus.address == ADDR_SAMPLE_COUNT);
    assign w_valid_ext   = MAX_CH'(in_valid);
    assign w_pop         = popcount(w_valid_ext);
    assign w_unused_bits = ^bus.writedata;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        garduino_adc_chan #(.DATA_W(DATA_W)) u_chan (
            .clk      (clk),
            .reset    (reset),
            .i_valid  (in_valid[c]),
            .i_data   (in_data[c*DATA_W +: DATA_W]),
            .i_rd_clr (bus.read && (bus.address == 4'(int'(ADDR_DATA0) + c))),
            .i_clr_new(w_wr_status && bus.writedata[NEW_LSB + c]),
            .i_clr_ovr(w_wr_status && bus.writedata[OVR_LSB + c]),
            .o_data   (w_data[c]),
            .o_new    (w_new[c]),
            .o_ovr    (w_ovr[c])
        );
    end

    // Zeroing comes first so a same-cycle increment lands on top of it.
    always_ff @(posedge clk) begin
        if (reset)           r_count <= '0;
        else if (w_wr_count) r_count <= 32'(w_pop);
        else                 r_count <= r_count + 32'(w_pop);
    end

`ifdef GARDUINO_ADC_IRQ_EN
    logic              w_wr_mask;
    logic [NUM_CH-1:0] r_new_mask;
    logic [NUM_CH-1:0] r_ovr_mask;
    logic              r_irq;

    assign w_wr_mask = bus.write && (bus.address == ADDR_IRQ_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_new_mask <= '0;
            r_ovr_mask <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_mask) begin
                r_new_mask <= bus.writedata[NEW_LSB +: NUM_CH];
                r_ovr_mask <= bus.writedata[OVR_LSB +: NUM_CH];
            end
            r_irq <= (|(w_new & r_new_mask)) | (|(w_ovr & r_ovr_mask));
        end
    end

    assign w_mask_rd = (32'(r_new_mask) << NEW_LSB) | (32'(r_ovr_mask) << OVR_LSB);
    assign irq       = r_irq;
`else
    assign w_mask_rd = '0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        // NOTE: defaulting every output first keeps this block free of latches.
        w_status                   = '0;
        w_status[NEW_LSB +: NUM_CH] = w_new;
        w_status[OVR_LSB +: NUM_CH] = w_ovr;
    end

    always_comb begin
        w_rd_value = '0;
        case (bus.address)
            ADDR_STATUS:       w_rd_value = w_status;
            ADDR_IRQ_MASK:     w_rd_value = w_mask_rd;
            ADDR_SAMPLE_COUNT: w_rd_value = r_count;
            default:           w_rd_value = '0;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.address == 4'(int'(ADDR_DATA0) + c)) w_rd_value = 32'(w_data[c]);
        end
    end

    // NOTE: state is updated with non-blocking '<=' so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)         r_readdata <= '0;
        else if (bus.read) r_readdata <= w_rd_value;
        else               r_readdata <= '0;
    end

    assign bus.readdata = r_readdata;

endmodule

// File: tb/tb_garduino_adc_capture.sv
// Self-checking bench for garduino_adc_capture: directed register-map cases
// followed by randomized traffic against a behavioural register model.
module tb_garduino_adc_capture;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 12;
    localparam int DW_ALL = NUM_CH * DATA_W;

`ifdef GARDUINO_ADC_IRQ_EN
    localparam bit IRQ_BUILT = 1'b1;
`else
    localparam bit IRQ_BUILT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] in_valid;
    logic [DW_ALL-1:0] in_data;
    wire               irq;

    garduino_adc_capture_if bus ();

    garduino_adc_capture #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .in_valid(in_valid),
        .in_data (in_data),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit model_en = 1'b0;

    // Behavioural register model: what software would see after each edge.
    logic [DATA_W-1:0] m_data [NUM_CH];
    logic [NUM_CH-1:0] m_new, m_ovr, m_nmask, m_omask;
    logic [31:0]       m_count, m_rd;
    logic              m_irq;
    logic              preset_req = 1'b0;
    logic [31:0]       preset_val = 32'h0;

    function automatic logic [31:0] m_base();
        return preset_req ? preset_val : m_count;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] v;
        int idx;
        v = 32'h0;
        idx = int'(a) - 4;
        if (a == 4'd0) begin
            for (int c = 0; c < NUM_CH; c++) begin
                v[c]     = m_new[c];
                v[8 + c] = m_ovr[c];
            end
        end else if (a == 4'd1) begin
            if (IRQ_BUILT) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    v[c]     = m_nmask[c];
                    v[8 + c] = m_omask[c];
                end
            end
        end else if (a == 4'd2) begin
            v = m_base();
        end else if (idx >= 0 && idx < NUM_CH) begin
            v = 32'(m_data[idx]);
        end
        return v;
    endfunction

    function automatic bit m_consumed(input int c);
        return (bus.read && bus.address == 4'(4 + c)) ||
               (bus.write && bus.address == 4'd0 && bus.writedata[c]);
    endfunction

    function automatic bit m_ovr_clr(input int c);
        return bus.write && bus.address == 4'd0 && bus.writedata[8 + c];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_new   <= '0;
            m_ovr   <= '0;
            m_nmask <= '0;
            m_omask <= '0;
            m_count <= '0;
            m_rd    <= '0;
            m_irq   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) m_data[c] <= '0;
        end else begin
            m_rd    <= bus.read ? m_read(bus.address) : 32'h0;
            m_irq   <= IRQ_BUILT && ((|(m_new & m_nmask)) || (|(m_ovr & m_omask)));
            m_count <= ((bus.write && bus.address == 4'd2) ? 32'h0 : m_base())
                       + 32'($countones(in_valid));
            if (IRQ_BUILT && bus.write && bus.address == 4'd1) begin
                m_nmask <= bus.writedata[NUM_CH-1:0];
                m_omask <= bus.writedata[8 +: NUM_CH];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_valid[c]) m_data[c] <= in_data[c*DATA_W +: DATA_W];
                m_new[c] <= in_valid[c] || (m_new[c] && !m_consumed(c));
                m_ovr[c] <= (in_valid[c] && m_new[c] && !m_consumed(c)) ||
                            (m_ovr[c] && !m_ovr_clr(c));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle; the DUT is compared against the model after every edge.
    task automatic cyc(input logic [3:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic [NUM_CH-1:0] v,
                       input logic [DW_ALL-1:0] d);
        bus.address   = a;
        bus.read      = rd;
        bus.write     = wr;
        bus.writedata = wd;
        in_valid      = v;
        in_data       = d;
        @(posedge clk);
        #1;
        if (model_en) begin
            check("model_readdata", bus.readdata, m_rd);
            check("model_irq", {31'b0, irq}, {31'b0, m_irq});
        end
    endtask

    task automatic idle();
        cyc(4'd0, 1'b0, 1'b0, 32'h0, '0, '0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd);
        cyc(a, 1'b0, 1'b1, wd, '0, '0);
    endtask

    task automatic expect_rd(input string name, input logic [3:0] a, input logic [31:0] exp);
        cyc(a, 1'b0 ^ 1'b1, 1'b0, 32'h0, '0, '0);
        check(name, bus.readdata, exp);
    endtask

    function automatic logic [DW_ALL-1:0] rand_data();
        return DW_ALL'({$urandom(), $urandom()});
    endfunction

    initial begin
        reset = 1'b1;
        idle();
        model_en = 1'b1;
        idle();
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        // Single capture, read-back and NEW clear
        cyc(4'd0, 1'b0, 1'b0, 32'h0, 4'b0001, 48'h000_000_000_ABC);
        expect_rd("data0_abc", 4'd4, 32'h0000_0ABC);
        expect_rd("status_after_read", 4'd0, 32'h0);

        // Back-to-back strobes on ch1 raise overrun
        cyc(4'd0, 1'b0, 1'b0, 32'h0, 4'b0010, 48'h000_000_111_000);
        cyc(4'd0, 1'b0, 1'b0, 32'h0, 4'b0010, 48'h000_000_222_000);
        expect_rd("status_ovr1", 4'd0, 32'h0000_0202);
        wr(4'd0, 32'h0000_0200);
        expect_rd("status_w1c_ovr", 4'd0, 32'h0000_0002);

        // Read of DATA_1 racing a new ch1 strobe
        cyc(4'd5, 1'b1, 1'b0, 32'h0, 4'b0010, 48'h000_000_333_000);
        check("data1_pre_update", bus.readdata, 32'h0000_0222);
        expect_rd("status_race", 4'd0, 32'h0000_0002);
        expect_rd("data1_333", 4'd5, 32'h0000_0333);
        expect_rd("status_clear", 4'd0, 32'h0);

        // Sample counter wrap and zeroing write
        preset_val = 32'hFFFF_FFFF;
        force dut.r_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_count;
        preset_req = 1'b1;
        cyc(4'd0, 1'b0, 1'b0, 32'h0, 4'b1111, rand_data());
        preset_req = 1'b0;
        expect_rd("count_wrap", 4'd2, 32'h0000_0003);
        cyc(4'd2, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011, rand_data());
        expect_rd("count_zero_inc", 4'd2, 32'h0000_0002);

        // Masked NEW interrupt
        wr(4'd0, 32'h0000_FFFF);
        wr(4'd1, 32'h0000_0001);
        cyc(4'd0, 1'b0, 1'b0, 32'h0, 4'b0001, rand_data());
        check("irq_not_yet", {31'b0, irq}, 32'h0);
        idle();
        check("irq_asserted", {31'b0, irq}, {31'b0, IRQ_BUILT});
        wr(4'd0, 32'h0000_0001);
        check("irq_held_one_cycle", {31'b0, irq}, {31'b0, IRQ_BUILT});
        idle();
        check("irq_cleared", {31'b0, irq}, 32'h0);
        expect_rd("mask_readback", 4'd1, IRQ_BUILT ? 32'h0000_0001 : 32'h0);
        expect_rd("reserved_zero", 4'd3, 32'h0);
        expect_rd("unmapped_zero", 4'd15, 32'h0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  a;
            logic        rd, w;
            a  = 4'($urandom_range(0, 15));
            rd = 1'($urandom_range(0, 1));
            w  = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 399) == 0);
            cyc(a, rd, w, $urandom(), NUM_CH'($urandom()), rand_data());
        end
        reset = 1'b0;

        // Reset in the middle of full-rate traffic
        cyc(4'd0, 1'b0, 1'b0, 32'h0, 4'b1111, rand_data());
        reset = 1'b1;
        cyc(4'd5, 1'b1, 1'b0, 32'h0, 4'b1111, rand_data());
        reset = 1'b0;
        check("midreset_readdata", bus.readdata, 32'h0);
        check("midreset_irq", {31'b0, irq}, 32'h0);
        for (int a = 0; a < 16; a++) expect_rd("post_reset_reg", 4'(a), 32'h0);
        check("post_reset_irq", {31'b0, irq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
